// File: rtl/cbm2_segment_ctl.sv
// cbm2_segment_ctl
// -----------------------------------------------------------------------------
// 6509-style segment logic for the CBM-II bus decoder. Holds the execution
// (exec, $0000) and indirection (ind, $0001) segment registers, visible at
// those addresses in every segment. An optional opcode tracker steers the
// data cycles of LDA (zp),Y and STA (zp),Y onto the indirection segment.
//
// Optional feature macro: CBM2_INDIRECT_EN
//   defined   -> opcode tracker present, (zp),Y data cycles use ind
//   undefined -> cpuSeg always follows exec; ind stays readable/writable
//
// Parameters:
//   RESET_SEG  value loaded into both segment registers on reset
//
// Ports:
//   clk_sys   in   system clock
//   reset_n   in   asynchronous active-low reset
//   cpuCycle  in   strobe: current CPU bus cycle completes at this edge
//   cpuSync   in   current cycle is an opcode fetch
//   cpuAddr   in   CPU address [15:0]
//   cpuDo     in   CPU write data [7:0]
//   cpuDi     in   CPU read data from the bus decoder [7:0]
//   cpuWe     in   CPU write
//   cpuSeg    out  segment for the current cycle, {4'h0, seg}
//   regSel    out  current cycle reads $0000/$0001
//   regDo     out  register readback, {4'h0, reg}
//   execSeg   out  execution register (savestate/debug)
//   indSeg    out  indirection register (savestate/debug)
// -----------------------------------------------------------------------------
module cbm2_segment_ctl #(
  parameter logic [3:0] RESET_SEG = 4'hF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpuCycle,
  input  logic        cpuSync,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDo,
  input  logic [7:0]  cpuDi,
  input  logic        cpuWe,
  output logic [7:0]  cpuSeg,
  output logic        regSel,
  output logic [7:0]  regDo,
  output logic [3:0]  execSeg,
  output logic [3:0]  indSeg
);

  logic [3:0] exec_q;
  logic [3:0] ind_q;
  logic       reg_addr;
  logic       use_ind;

  // $0000/$0001 decode ignores the segment: the registers appear everywhere.
  assign reg_addr = (cpuAddr[15:1] == 15'h0000);

  // Segment registers. The write still reaches memory; only the low nibble
  // of the data is kept.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      exec_q <= RESET_SEG;
      ind_q  <= RESET_SEG;
    end else if (cpuCycle && cpuWe && reg_addr) begin
      if (cpuAddr[0]) begin
        ind_q <= cpuDo[3:0];
      end else begin
        exec_q <= cpuDo[3:0];
      end
    end
  end

`ifdef CBM2_INDIRECT_EN
  typedef enum logic {
    FETCH,
    INDIRECT
  } state_t;

  logic [7:0] opc_q;
  logic [7:0] opc_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  state_t     state;

  // Tracker registers: opcode of the current instruction and the number of
  // bus cycles completed since its fetch.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      opc_q <= 8'h00;
      cnt_q <= 3'd0;
    end else begin
      opc_q <= opc_d;
      cnt_q <= cnt_d;
    end
  end

  // Next tracker values and the decoded state. The state is a pure function
  // of the registered opcode/count, so it needs no register of its own.
  // With cnt counting from 1 after the fetch, cnt==4 is the first data cycle
  // of (zp),Y; the saturating count keeps INDIRECT up for the page-cross /
  // write cycle until the next sync.
  always_comb begin
    opc_d = opc_q;
    cnt_d = cnt_q;
    state = FETCH;
    if (cpuCycle) begin
      if (cpuSync) begin
        opc_d = cpuDi;
        cnt_d = 3'd1;
      end else if (cnt_q != 3'd7) begin
        cnt_d = cnt_q + 3'd1;
      end
    end
    if (((opc_q == 8'hB1) || (opc_q == 8'h91)) && (cnt_q >= 3'd4)) begin
      state = INDIRECT;
    end
  end

  // A sync cycle is the next opcode fetch and always runs from exec.
  assign use_ind = (state == INDIRECT) && !cpuSync;

  logic unused_bits;
  assign unused_bits = &{1'b0, cpuDo[7:4]};
`else
  assign use_ind = 1'b0;

  logic unused_bits;
  assign unused_bits = &{1'b0, cpuDo[7:4], cpuSync, cpuDi};
`endif

  assign cpuSeg  = {4'h0, use_ind ? ind_q : exec_q};
  assign regSel  = !cpuWe && reg_addr;
  assign regDo   = {4'h0, cpuAddr[0] ? ind_q : exec_q};
  assign execSeg = exec_q;
  assign indSeg  = ind_q;

endmodule

// File: tb/tb_cbm2_segment_ctl.sv
// tb_cbm2_segment_ctl
// -----------------------------------------------------------------------------
// Testbench for cbm2_segment_ctl. Stimulus drives one clock per call and
// queues the expected outputs for that clock; a monitor on the falling edge
// pops and compares them. Honours CBM2_INDIRECT_EN for the ind-cycle value.
// -----------------------------------------------------------------------------
module tb_cbm2_segment_ctl;

  typedef struct {
    string      name;
    logic [7:0] seg;
    logic       sel;
    logic [7:0] rdo;
    logic [3:0] exec_v;
    logic [3:0] ind_v;
  } exp_t;

`ifdef CBM2_INDIRECT_EN
  localparam logic [7:0] IND_SEG = 8'h02;
`else
  localparam logic [7:0] IND_SEG = 8'h0F;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cpuCycle;
  logic        cpuSync;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDo;
  logic [7:0]  cpuDi;
  logic        cpuWe;
  logic [7:0]  cpuSeg;
  logic        regSel;
  logic [7:0]  regDo;
  logic [3:0]  execSeg;
  logic [3:0]  indSeg;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Register contents the bench expects, updated as writes are issued.
  logic [3:0] m_exec;
  logic [3:0] m_ind;

  cbm2_segment_ctl #(.RESET_SEG(4'hF)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .cpuCycle(cpuCycle),
    .cpuSync (cpuSync),
    .cpuAddr (cpuAddr),
    .cpuDo   (cpuDo),
    .cpuDi   (cpuDi),
    .cpuWe   (cpuWe),
    .cpuSeg  (cpuSeg),
    .regSel  (regSel),
    .regDo   (regDo),
    .execSeg (execSeg),
    .indSeg  (indSeg)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_output(input string name, input logic [7:0] act,
                              input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, req);
    end
  endtask

  // Monitor: every queued expectation belongs to the clock it was pushed in.
  always @(negedge clk_sys) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output({e.name, ".cpuSeg"}, cpuSeg, e.seg);
      check_output({e.name, ".regSel"}, {7'd0, regSel}, {7'd0, e.sel});
      check_output({e.name, ".regDo"}, regDo, e.rdo);
      check_output({e.name, ".execSeg"}, {4'd0, execSeg}, {4'd0, e.exec_v});
      check_output({e.name, ".indSeg"}, {4'd0, indSeg}, {4'd0, e.ind_v});
    end
  end

  function automatic exp_t make_exp(input string name, input logic [7:0] seg);
    exp_t e;
    e.name   = name;
    e.seg    = seg;
    e.sel    = !cpuWe && (cpuAddr[15:1] == 15'h0000);
    e.rdo    = {4'h0, cpuAddr[0] ? m_ind : m_exec};
    e.exec_v = m_exec;
    e.ind_v  = m_ind;
    return e;
  endfunction

  // One clock of stimulus; exp_seg is the hand-computed segment for it.
  task automatic apply_stimulus(input string name, input logic cyc,
                                input logic sync, input logic [15:0] addr,
                                input logic [7:0] dout, input logic [7:0] din,
                                input logic we, input logic [7:0] exp_seg);
    @(posedge clk_sys);
    #1;
    cpuCycle = cyc;
    cpuSync  = sync;
    cpuAddr  = addr;
    cpuDo    = dout;
    cpuDi    = din;
    cpuWe    = we;
    exp_q.push_back(make_exp(name, exp_seg));
    if (cyc && we && addr == 16'h0000) m_exec = dout[3:0];
    if (cyc && we && addr == 16'h0001) m_ind  = dout[3:0];
  endtask

  initial begin
    reset_n  = 1'b0;
    cpuCycle = 1'b0;
    cpuSync  = 1'b0;
    cpuAddr  = 16'hFFFC;
    cpuDo    = 8'h00;
    cpuDi    = 8'h00;
    cpuWe    = 1'b0;
    m_exec   = 4'hF;
    m_ind    = 4'hF;

    // Reset state
    @(posedge clk_sys);
    #1;
    exp_q.push_back(make_exp("reset", 8'h0F));
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;

    // Basic cycles, readback and register writes
    apply_stimulus("first",   1, 1, 16'h1000, 8'h00, 8'hEA, 0, 8'h0F);
    apply_stimulus("rd0001",  1, 0, 16'h0001, 8'h00, 8'h0F, 0, 8'h0F);
    apply_stimulus("wr0000",  1, 0, 16'h0000, 8'hA1, 8'h00, 1, 8'h0F);
    apply_stimulus("rd0000",  1, 0, 16'h0000, 8'h00, 8'h01, 0, 8'h01);
    apply_stimulus("wr0001",  1, 0, 16'h0001, 8'h02, 8'h00, 1, 8'h01);
    apply_stimulus("wr0000b", 1, 0, 16'h0000, 8'h0F, 8'h00, 1, 8'h01);

    // LDA ($20),Y without page cross, exec=F ind=2
    apply_stimulus("lda0", 1, 1, 16'h2000, 8'h00, 8'hB1, 0, 8'h0F);
    apply_stimulus("lda1", 1, 0, 16'h2001, 8'h00, 8'h20, 0, 8'h0F);
    apply_stimulus("lda2", 1, 0, 16'h0020, 8'h00, 8'h00, 0, 8'h0F);
    apply_stimulus("lda3", 1, 0, 16'h0021, 8'h00, 8'h30, 0, 8'h0F);
    apply_stimulus("lda4", 1, 0, 16'h3005, 8'h00, 8'h55, 0, IND_SEG);
    apply_stimulus("lda_next", 1, 1, 16'h2002, 8'h00, 8'hEA, 0, 8'h0F);
    apply_stimulus("nop1", 1, 0, 16'h2003, 8'h00, 8'hEA, 0, 8'h0F);

    // STA ($20),Y with a three-clock stall inside cycle 4
    apply_stimulus("sta0", 1, 1, 16'h2010, 8'h00, 8'h91, 0, 8'h0F);
    apply_stimulus("sta1", 1, 0, 16'h2011, 8'h00, 8'h20, 0, 8'h0F);
    apply_stimulus("sta2", 1, 0, 16'h0020, 8'h00, 8'h00, 0, 8'h0F);
    apply_stimulus("sta3", 1, 0, 16'h0021, 8'h00, 8'h30, 0, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus("sta4_stall", 0, 0, 16'h3005, 8'h00, 8'h00, 0, IND_SEG);
    end
    apply_stimulus("sta4", 1, 0, 16'h3005, 8'h00, 8'h00, 0, IND_SEG);
    apply_stimulus("sta5", 1, 0, 16'h3005, 8'h77, 8'h00, 1, IND_SEG);
    apply_stimulus("sta_next", 1, 1, 16'h2012, 8'h00, 8'hEA, 0, 8'h0F);

    // Reset asserted during cycle 4 of LDA (zp),Y
    apply_stimulus("rlda0", 1, 1, 16'h2020, 8'h00, 8'hB1, 0, 8'h0F);
    apply_stimulus("rlda1", 1, 0, 16'h2021, 8'h00, 8'h20, 0, 8'h0F);
    apply_stimulus("rlda2", 1, 0, 16'h0020, 8'h00, 8'h00, 0, 8'h0F);
    apply_stimulus("rlda3", 1, 0, 16'h0021, 8'h00, 8'h30, 0, 8'h0F);
    @(posedge clk_sys);
    #1;
    cpuSync = 1'b0;
    cpuAddr = 16'h3005;
    cpuDi   = 8'h55;
    reset_n = 1'b0;
    m_exec  = 4'hF;
    m_ind   = 4'hF;
    exp_q.push_back(make_exp("rlda4_reset", 8'h0F));
    @(posedge clk_sys);
    #1;
    cpuCycle = 1'b0;
    reset_n  = 1'b1;
    apply_stimulus("after_reset", 1, 0, 16'h4000, 8'h00, 8'h00, 0, 8'h0F);
    apply_stimulus("rd0001_rst",  1, 0, 16'h0001, 8'h00, 8'h0F, 0, 8'h0F);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_sys);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/cbm2_segment_ctl.md
# cbm2_segment_ctl

Models the 6509 segment logic that drives `cpuSeg` into the CBM-II bus decoder. It holds the execution and indirection segment registers mapped at $0000/$0001 of every segment. It tracks the opcode stream so that the data cycles of `LDA (zp),Y` and `STA (zp),Y` use the indirection segment. It sits between the 6502 core and `cbm2_buslogic`, and supplies the register readback data for $0000/$0001.

## Interface
Parameters:
- `RESET_SEG`, default 4'hF: value loaded into both segment registers on reset.

Ports:
- `clk_sys`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `cpuCycle`  in  1  one-`clk_sys` strobe; the current CPU bus cycle completes at this edge
- `cpuSync`  in  1  core flags the current cycle as an opcode fetch; valid for the whole cycle
- `cpuAddr`  in  16  CPU address
- `cpuDo`  in  8  CPU write data
- `cpuDi`  in  8  CPU read data, as returned by the bus decoder
- `cpuWe`  in  1  CPU write
- `cpuSeg`  out  8  segment for the current cycle, `{4'h0, seg}`
- `regSel`  out  1  current cycle is a read of $0000/$0001; the CPU data mux takes `regDo`
- `regDo`  out  8  register readback, `{4'h0, reg}`
- `execSeg`  out  4  execution register (savestate/debug)
- `indSeg`  out  4  indirection register (savestate/debug)

## Operation
- The registers are `exec` (at $0000) and `ind` (at $0001), both 4 bits. They respond to these addresses in any segment.
- **Write:** `cpuCycle & cpuWe & cpuAddr==16'h0000` loads `exec <= cpuDo[3:0]`; address $0001 loads `ind` the same way.
  - The write also proceeds to memory; this block does not suppress `cs_*`.
- **Read:** `regSel = !cpuWe & cpuAddr[15:1]==0`, independent of `cpuCycle`. `regDo` is `{4'h0, exec}` for $0000 and `{4'h0, ind}` for $0001.
- **Opcode tracker state:**
  - `opc[7:0]`, the opcode latched from `cpuDi` on a `cpuCycle & cpuSync` edge.
  - `cnt[2:0]`, the cycles since sync. A sync edge sets `cnt` to 1; any other `cpuCycle` edge increments it, saturating at 7.
  - `armed = (opc==8'hB1 || opc==8'h91) && cnt>=4`.
- **States:**
  - FETCH: after reset or a sync, while `cnt<4` or the opcode does not match.
  - INDIRECT: `armed`.
  - A `cpuSync` cycle always returns to FETCH.
- **Segment output (combinational):** `cpuSeg = {4'h0, (armed && !cpuSync) ? ind : exec}`.
  - `LDA (zp),Y`: cycle 4 uses `ind`. On a page cross, cycle 5 also uses `ind`.
  - `STA (zp),Y`: cycles 4 and 5 (the dummy read and the write) use `ind`.
  - Every other cycle uses `exec`.
- Interrupt sequences are seen as non-matching opcodes and always use `exec`.

## Timing
- Reset values: `exec=ind=RESET_SEG`, `opc=8'h00`, `cnt=0`, `cpuSeg=8'h0F` (default), `regSel=0`, `regDo=8'h0F`.
- All state updates only on `clk_sys` edges with `cpuCycle=1`. With `cpuCycle=0` (RDY stall, video slot) all state holds and `cpuSeg` remains stable.
- A register write takes effect on the next bus cycle. Within the writing cycle, `cpuSeg` uses the old value.
- A write to $0000 during an INDIRECT cycle updates `exec` but does not cancel INDIRECT.
- Simultaneous sync and register address: the sync takes priority for the tracker, and the write/readback still apply.
- Asserting `reset_n` mid-instruction clears all state immediately; the first cycle after release uses `RESET_SEG`.
- Zero latency from `cpuSync`/`cpuAddr` to `cpuSeg`/`regSel`/`regDo`: combinational paths from registered state.

## Configuration
- `CBM2_INDIRECT_EN` defined: opcode tracker present; behaviour as above.
- Not defined:
  - Tracker omitted.
  - `cpuSeg = {4'h0, exec}` always.
  - `ind` remains readable and writable.

## Test plan
- Release reset and issue any cycle -> `cpuSeg=8'h0F`. Read $0001 -> `regSel=1`, `regDo=8'h0F`.
- Write $0000=$A1 in segment 15 -> next cycle `cpuSeg=8'h01`. Read $0000 -> `regDo=8'h01`.
- `exec=15`, `ind=2`, `LDA ($20),Y` with no page cross (5 cycles) -> `cpuSeg` is 15,15,15,15,2, then 15 at the next sync.
- Same setup with `STA ($20),Y` (6 cycles), with `cpuCycle` held low for 3 clocks inside cycle 4 -> cycles 4–5 give `cpuSeg=2` and hold through the stall; cycles 0–3 give 15.
- Assert `reset_n` during cycle 4 of `LDA (zp),Y` with `ind=2` -> `cpuSeg=8'h0F` immediately, and `exec=ind=F` after release.
- Build without `CBM2_INDIRECT_EN` and repeat scenario 3 -> `cpuSeg=15` on all cycles.
